// File: rtl/psram_ctrl_pkg.sv
// Shared constants and state encoding for the PSRAM access scheduler.
package psram_ctrl_pkg;

  // Command codes presented to the PSRAM driver on read_write
  localparam logic [1:0] RW_NONE  = 2'd0;
  localparam logic [1:0] RW_WRITE = 2'd1;
  localparam logic [1:0] RW_READ  = 2'd2;

  // Word returned to the readback path when a read never completes
  localparam logic [15:0] READ_TIMEOUT_DATA = 16'hDEAD;

  // Scheduler sequencing states
  typedef enum logic [2:0] {
    WAIT_INIT = 3'd0,
    IDLE      = 3'd1,
    ISSUE     = 3'd2,
    BUSY      = 3'd3,
    GAP       = 3'd4
  } sched_state_t;

endpackage

// File: rtl/psram_access_scheduler_fifo.sv
// Synchronous sample FIFO feeding the PSRAM write path.
// The head word is visible combinationally on dout so the scheduler can latch
// it in the same cycle it pops. A pop on a full FIFO frees a slot for a push
// arriving in that same cycle.
module sample_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    wr_idx;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_idx];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      rd_idx <= '0;
      wr_idx <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + AW'(1);
      if (do_pop)  rd_idx <= rd_idx + AW'(1);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // Sample storage; contents are don't-care until written so no reset
  always_ff @(posedge mem_clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/psram_access_scheduler.sv
// PSRAM access scheduler: after the driver reports QPI mode, drains buffered
// ADC samples to linearly incrementing addresses and interleaves single-word
// readbacks, one transaction at a time with a CE-high gap and a hang timeout.
module psram_access_scheduler
  import psram_ctrl_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter int          HI_WATER   = 6,
  parameter logic [22:0] ADDR_LAST  = 23'h7FFFFF,
  parameter int          GAP_CYCLES = 2,
  parameter int          TIMEOUT    = 64
) (
  input  logic        mem_clk,
  input  logic        rst,
  input  logic        smp_valid,
  input  logic [15:0] smp_data,
  input  logic        rd_req,
  input  logic [22:0] rd_addr,
  output logic        rd_ack,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  input  logic        qpi_on,
  input  logic        endcommand,
  input  logic [15:0] mem_rdata,
  output logic [22:0] address,
  output logic [1:0]  read_write,
  output logic        quad_start,
  output logic [15:0] data_in,
  output logic [22:0] wr_ptr,
  output logic        overflow,
  output logic        timeout_err
);

  localparam int LW    = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2((TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES) + 1;

  sched_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      fifo_head;
  logic [LW-1:0]    fifo_level;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             above_water;
  logic             choose_write;
  logic             choose_read;
  logic             endcmd_q;
  logic             endcmd_q2;
  logic             endcmd_rise;
  logic             busy_expired;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .mem_clk (mem_clk),
    .rst     (rst),
    .push    (smp_valid),
    .pop     (fifo_pop),
    .din     (smp_data),
    .dout    (fifo_head),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A nearly full FIFO must drain before readbacks are allowed to cut in
  assign above_water  = (fifo_level >= LW'(HI_WATER));
  assign choose_write = (state == IDLE) && (above_water || (!rd_req && !fifo_empty));
  assign choose_read  = (state == IDLE) && rd_req && !above_water;
  assign fifo_pop     = choose_write;
  assign rd_ack       = choose_read;
  assign endcmd_rise  = endcmd_q && !endcmd_q2;
  assign busy_expired = (cnt == CNT_W'(TIMEOUT - 1));

  // Resynchronise the driver's completion flag and keep its previous value for edge detection
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      endcmd_q  <= 1'b0;
      endcmd_q2 <= 1'b0;
    end else begin
      endcmd_q  <= endcommand;
      endcmd_q2 <= endcmd_q;
    end
  end

  // Sticky flag: a sample arrived with no room, even after this cycle's pop
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (smp_valid && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

  // Transaction sequencer: arbitrate, pulse start, wait for completion or timeout, then hold CE high
  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state       <= WAIT_INIT;
      cnt         <= '0;
      address     <= '0;
      read_write  <= RW_NONE;
      data_in     <= '0;
      quad_start  <= 1'b0;
      wr_ptr      <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      quad_start <= 1'b0;
      rd_valid   <= 1'b0;
      case (state)
        WAIT_INIT: begin
          if (qpi_on) state <= IDLE;
        end
        IDLE: begin
          if (choose_write) begin
            address    <= wr_ptr;
            read_write <= RW_WRITE;
            data_in    <= fifo_head;
            quad_start <= 1'b1;
            state      <= ISSUE;
          end else if (choose_read) begin
            address    <= rd_addr;
            read_write <= RW_READ;
            quad_start <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          if (endcmd_rise || busy_expired) begin
            if (read_write == RW_WRITE) begin
              wr_ptr <= (wr_ptr == ADDR_LAST) ? '0 : wr_ptr + 23'd1;
            end else begin
              rd_valid <= 1'b1;
              rd_data  <= endcmd_rise ? mem_rdata : READ_TIMEOUT_DATA;
            end
            if (!endcmd_rise) timeout_err <= 1'b1;
            read_write <= RW_NONE;
            cnt        <= '0;
            state      <= GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= WAIT_INIT;
      endcase
    end
  end

endmodule
